// File: rtl/stream_merge_rr.sv
// Two-channel ready/valid merge: per-channel FIFOs, round-robin arbiter,
// registered output stage. Each output word carries its source channel.
module stream_merge_rr #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] I_0_data,
  input  logic             I_0_valid,
  output logic             I_0_ready,
  input  logic [WIDTH-1:0] I_1_data,
  input  logic             I_1_valid,
  output logic             I_1_ready,
  output logic [WIDTH-1:0] O_data,
  output logic             O_src,
  output logic             O_valid,
  input  logic             O_ready
);

  localparam int unsigned NCH = 2;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]          mem_q [NCH][DEPTH];
  logic [NCH-1:0][PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [NCH-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [NCH-1:0]            in_valid_c, in_ready_c, push_c, pop_c, nonempty_c;
  logic [NCH-1:0][WIDTH-1:0] in_data_c;
  logic                      last_q, last_d;
  logic                      grant_c, load_c;
  logic                      ov_q, ov_d;
  logic                      osrc_q, osrc_d;
  logic [WIDTH-1:0]          od_q, od_d;

  assign in_valid_c = {I_1_valid, I_0_valid};
  assign in_data_c  = {I_1_data, I_0_data};

  // Ready depends only on stored occupancy; held low while reset is asserted.
  always_comb begin
    in_ready_c = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ready_c[k] = ~ASYNCRESET & (cnt_q[k] != CW'(DEPTH));
    end
  end

  assign I_0_ready = in_ready_c[0];
  assign I_1_ready = in_ready_c[1];
  assign O_data    = od_q;
  assign O_src     = osrc_q;
  assign O_valid   = ov_q;

  // Arbitration, FIFO bookkeeping and output-stage next state.
  always_comb begin
    nonempty_c = '0;
    push_c     = '0;
    pop_c      = '0;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    grant_c    = 1'b0;
    load_c     = 1'b0;
    ov_d       = ov_q;
    od_d       = od_q;
    osrc_d     = osrc_q;
    last_d     = last_q;

    for (int k = 0; k < NCH; k++) begin
      nonempty_c[k] = (cnt_q[k] != '0);
    end

    // Contested: alternate away from the last winner; otherwise take whoever has data.
    if (&nonempty_c) begin
      grant_c = ~last_q;
    end else begin
      grant_c = nonempty_c[1];
    end

    load_c = (~ov_q | O_ready) & (|nonempty_c);

    for (int k = 0; k < NCH; k++) begin
      push_c[k] = in_valid_c[k] & in_ready_c[k];
      pop_c[k]  = load_c & (grant_c == 1'(k));
      cnt_d[k]  = cnt_q[k] + CW'(push_c[k]) - CW'(pop_c[k]);
      wr_d[k]   = wr_q[k] + PW'(push_c[k]);
      rd_d[k]   = rd_q[k] + PW'(pop_c[k]);
    end

    if (load_c) begin
      ov_d   = 1'b1;
      od_d   = mem_q[grant_c][rd_q[grant_c]];
      osrc_d = grant_c;
      last_d = grant_c;
    end else if (O_ready) begin
      ov_d = 1'b0;
    end
  end

  // Control state; last resets to 1 so channel 0 wins the first contest.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= 1'b1;
      ov_q   <= 1'b0;
      od_q   <= '0;
      osrc_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      last_q <= last_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      osrc_q <= osrc_d;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NCH; k++) begin
      if (push_c[k]) begin
        mem_q[k][wr_q[k]] <= in_data_c[k];
      end
    end
  end

endmodule

// File: tb/tb_stream_merge_rr.sv
// Directed bench for stream_merge_rr with a per-channel scoreboard.
module tb_stream_merge_rr;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned DEPTH = 2;

  logic             CLK = 1'b0;
  logic             ASYNCRESET = 1'b1;
  logic [WIDTH-1:0] I_0_data = '0;
  logic             I_0_valid = 1'b0;
  logic             I_0_ready;
  logic [WIDTH-1:0] I_1_data = '0;
  logic             I_1_valid = 1'b0;
  logic             I_1_ready;
  logic [WIDTH-1:0] O_data;
  logic             O_src;
  logic             O_valid;
  logic             O_ready = 1'b0;

  stream_merge_rr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .ASYNCRESET(ASYNCRESET),
    .I_0_data  (I_0_data),
    .I_0_valid (I_0_valid),
    .I_0_ready (I_0_ready),
    .I_1_data  (I_1_data),
    .I_1_valid (I_1_valid),
    .I_1_ready (I_1_ready),
    .O_data    (O_data),
    .O_src     (O_src),
    .O_valid   (O_valid),
    .O_ready   (O_ready)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  logic [WIDTH-1:0] log_data [$];
  logic             log_src [$];
  int               log_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Handshakes are decided by values stable across the next rising edge.
  always @(negedge CLK) begin
    if (!ASYNCRESET) begin
      if (O_valid && O_ready) begin
        log_data.push_back(O_data);
        log_src.push_back(O_src);
        log_cyc.push_back(cyc);
        if (O_src == 1'b0) begin
          chk("sb_src0_has_word", 32'(q0.size() != 0), 1);
          if (q0.size() != 0) chk("sb_src0_data", 32'(O_data), 32'(q0.pop_front()));
        end else begin
          chk("sb_src1_has_word", 32'(q1.size() != 0), 1);
          if (q1.size() != 0) chk("sb_src1_data", 32'(O_data), 32'(q1.pop_front()));
        end
      end
      if (I_0_valid && I_0_ready) q0.push_back(I_0_data);
      if (I_1_valid && I_1_ready) q1.push_back(I_1_data);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_sb();
    q0.delete();
    q1.delete();
    log_data.delete();
    log_src.delete();
    log_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    ASYNCRESET = 1'b1;
    I_0_valid = 1'b0;
    I_1_valid = 1'b0;
    O_ready = 1'b0;
    clear_sb();
    @(posedge CLK);
    #2;
    ASYNCRESET = 1'b0;
    step();
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int b;
    b = 0;
    while (log_data.size() < n && b < budget) begin
      step();
      b++;
    end
    chk(tag, 32'(log_data.size()), 32'(n));
  endtask

  initial begin
    logic [WIDTH-1:0] e2d [8];
    logic [WIDTH-1:0] e3d [5];
    logic             e3s [5];
    logic a0, a1;
    int i0, i1, n, acc, g;

    e2d = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19, 5'd4, 5'd20};
    e3d = '{5'd4, 5'd20, 5'd5, 5'd21, 5'd6};
    e3s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset values
    #2;
    chk("rst_o_valid", 32'(O_valid), 0);
    chk("rst_o_data", 32'(O_data), 0);
    chk("rst_o_src", 32'(O_src), 0);
    chk("rst_i0_ready", 32'(I_0_ready), 0);
    chk("rst_i1_ready", 32'(I_1_ready), 0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    ASYNCRESET = 1'b0;
    #1;
    chk("post_rst_i0_ready", 32'(I_0_ready), 1);
    chk("post_rst_i1_ready", 32'(I_1_ready), 1);
    step();

    // Single word latency
    O_ready = 1'b1;
    I_0_data = 5'h0A;
    I_0_valid = 1'b1;
    step();
    I_0_valid = 1'b0;
    chk("t1_no_bypass", 32'(O_valid), 0);
    step();
    chk("t1_o_valid", 32'(O_valid), 1);
    chk("t1_o_data", 32'(O_data), 32'h0A);
    chk("t1_o_src", 32'(O_src), 0);
    step();
    chk("t1_one_cycle", 32'(O_valid), 0);

    // Both channels streaming
    do_reset();
    O_ready = 1'b1;
    i0 = 0; i1 = 0; g = 0;
    while ((i0 < 4 || i1 < 4) && g < 40) begin
      I_0_valid = (i0 < 4);
      I_0_data = WIDTH'(1 + i0);
      I_1_valid = (i1 < 4);
      I_1_data = WIDTH'(17 + i1);
      a0 = I_0_valid && I_0_ready;
      a1 = I_1_valid && I_1_ready;
      step();
      if (a0) i0++;
      if (a1) i1++;
      g++;
    end
    I_0_valid = 1'b0;
    I_1_valid = 1'b0;
    wait_out(8, 20, "t2_drain");
    if (log_data.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t2_order_data", 32'(log_data[k]), 32'(e2d[k]));
        chk("t2_order_src", 32'(log_src[k]), 32'(k % 2));
      end
      chk("t2_no_gaps", 32'(log_cyc[7] - log_cyc[0]), 7);
    end

    // Back-pressure
    do_reset();
    O_ready = 1'b0;
    i0 = 0; i1 = 0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      I_0_valid = 1'b1;
      I_0_data = WIDTH'(4 + i0);
      I_1_valid = 1'b1;
      I_1_data = WIDTH'(20 + i1);
      a0 = I_0_ready;
      a1 = I_1_ready;
      step();
      if (a0) begin i0++; acc++; end
      if (a1) begin i1++; acc++; end
      if (O_valid) chk("t3_o_data_stable", 32'(O_data), 4);
    end
    chk("t3_accepted_total", 32'(acc), 5);
    chk("t3_i0_ready_low", 32'(I_0_ready), 0);
    chk("t3_i1_ready_low", 32'(I_1_ready), 0);
    chk("t3_o_valid_held", 32'(O_valid), 1);
    I_0_valid = 1'b0;
    I_1_valid = 1'b0;
    O_ready = 1'b1;
    wait_out(5, 20, "t3_drain");
    if (log_data.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t3_drain_data", 32'(log_data[k]), 32'(e3d[k]));
        chk("t3_drain_src", 32'(log_src[k]), 32'(e3s[k]));
      end
    end

    // Full FIFO with simultaneous pop and push
    do_reset();
    O_ready = 1'b0;
    n = 0; g = 0;
    I_0_valid = 1'b1;
    while (I_0_ready && g < 10) begin
      I_0_data = WIDTH'(8 + n);
      step();
      n++;
      g++;
    end
    chk("t4_filled_words", 32'(n), 3);
    chk("t4_full_ready_low", 32'(I_0_ready), 0);
    O_ready = 1'b1;
    I_0_data = WIDTH'(8 + n);
    step();
    chk("t4_ready_after_pop", 32'(I_0_ready), 1);
    for (int k = 0; k < 6; k++) begin
      I_0_data = WIDTH'(8 + n);
      chk("t4_ready_hold", 32'(I_0_ready), 1);
      chk("t4_o_valid", 32'(O_valid), 1);
      a0 = I_0_ready;
      step();
      if (a0) n++;
    end
    I_0_valid = 1'b0;
    wait_out(n, 20, "t4_drain");

    // Reset mid-stream
    O_ready = 1'b0;
    I_0_data = 5'h03;
    I_0_valid = 1'b1;
    I_1_data = 5'h13;
    I_1_valid = 1'b1;
    step();
    I_0_valid = 1'b0;
    I_1_data = 5'h12;
    step();
    I_1_valid = 1'b0;
    step();
    chk("t5_o_valid_before", 32'(O_valid), 1);
    #1;
    ASYNCRESET = 1'b1;
    #1;
    chk("t5_async_o_valid", 32'(O_valid), 0);
    chk("t5_async_i0_ready", 32'(I_0_ready), 0);
    chk("t5_async_i1_ready", 32'(I_1_ready), 0);
    clear_sb();
    @(posedge CLK);
    #2;
    ASYNCRESET = 1'b0;
    #1;
    chk("t5_post_i0_ready", 32'(I_0_ready), 1);
    chk("t5_post_i1_ready", 32'(I_1_ready), 1);
    O_ready = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_no_stale", 32'(O_valid), 0);
    end
    I_0_data = 5'h1F;
    I_0_valid = 1'b1;
    I_1_data = 5'h0E;
    I_1_valid = 1'b1;
    step();
    I_0_valid = 1'b0;
    I_1_valid = 1'b0;
    step();
    chk("t5_first_grant_src", 32'(O_src), 0);
    chk("t5_first_grant_data", 32'(O_data), 32'h1F);
    step();
    chk("t5_second_grant_src", 32'(O_src), 1);
    chk("t5_second_grant_data", 32'(O_data), 32'h0E);
    step();

    // Single-channel stream on channel 1
    do_reset();
    O_ready = 1'b1;
    i1 = 0; g = 0;
    while (i1 < 6 && g < 30) begin
      I_1_valid = 1'b1;
      I_1_data = WIDTH'(2 + i1);
      a1 = I_1_ready;
      step();
      if (a1) i1++;
      g++;
    end
    I_1_valid = 1'b0;
    wait_out(6, 20, "t6_drain");
    if (log_data.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t6_src", 32'(log_src[k]), 1);
        chk("t6_data", 32'(log_data[k]), 32'(2 + k));
      end
      chk("t6_no_idle", 32'(log_cyc[5] - log_cyc[0]), 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
